osnt_tuple_extractor: RTL and testbench
=======================================

# osnt_tuple_extractor

Passive header parser that taps the monitoring AXI4-Stream between the input arbiter and the output-port-lookup packet path. It extracts the IPv4 5-tuple and the one-hot ingress port of each packet. It then issues exactly one single-cycle lookup request per packet to the downstream TCAM packet filter (`tuple`, `src_port`, `lookup_req`). It never stalls or modifies the stream; it only observes accepted beats.

## Interface
- `C_S_AXIS_DATA_WIDTH`, 256: stream width. Only 256 is supported.
- `C_S_AXIS_TUSER_WIDTH`, 128: sideband width.
- `TUPLE_WIDTH`, 104: tuple width. Fixed layout `{src_ip[31:0], dst_ip[31:0], proto[7:0], l4_src[15:0], l4_dst[15:0]}`.
- `NUM_QUEUES`, 8: width of the one-hot source-port field.
- `SRC_PORT_POS`, 16: LSB of the source-port field in tuser.
- `clk` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `s_axis_tdata` in 256: beat data. Packet byte k sits at `tdata[8*(k%32)+:8]` of beat k/32.
- `s_axis_tuser` in 128: sideband; `src_port` = `tuser[SRC_PORT_POS+:NUM_QUEUES]`, sampled on the first beat.
- `s_axis_tvalid` in 1: observed only.
- `s_axis_tready` in 1: observed only (driven by the consumer).
- `s_axis_tlast` in 1: end of packet.
- `tuple` out 104: extracted tuple. Held stable from the `lookup_req` cycle until the next `lookup_req`.
- `src_port` out NUM_QUEUES: ingress port of the current tuple.
- `lookup_req` out 1: one-cycle pulse, exactly one per packet.

## Operation
- A beat is accepted when `tvalid & tready` are both high. Nothing is captured on other cycles.
- Multi-byte fields are in network order: lowest byte index is most significant.
- Field byte positions:
  - ethertype: bytes 12–13, must equal 0x0800
  - version/IHL: byte 14; version must be 4, IHL in 5..15
  - fragment offset: bytes 20–21, low 13 bits
  - proto: byte 23
  - src_ip: bytes 26–29
  - dst_ip: bytes 30–33
  - L4 ports: bytes L..L+3, where L = 14 + 4·IHL (L ≤ 74, so at most 3 beats)
- Classification:
  - Non-IPv4 ethertype, version ≠ 4, or IHL < 5: tuple = 0.
  - IPv4, proto ∉ {6, 17}, or fragment offset ≠ 0: IPs and proto captured, ports = 0.
  - IPv4 TCP/UDP unfragmented: full tuple.
  - Packet ends (tlast) before every required byte has arrived: tuple = 0 (truncated).
- FSM states:
  - IDLE: waiting for the first beat of a packet.
    - Accepted beat 0 latches src_port and beat-0 fields.
    - Tuple decided in beat 0 (non-IPv4/bad version/IHL, or tlast) → ISSUE; tlast also implies the next beat is a new packet.
    - Otherwise → HDR.
  - HDR: captures beats 1 and 2 as needed.
    - On the beat holding the last required byte → ISSUE.
    - tlast before that beat → tuple = 0 → ISSUE.
  - ISSUE: single cycle. Drive `lookup_req` = 1 and update `tuple`/`src_port`.
    - → IDLE if the triggering beat had tlast.
    - Otherwise → WAIT_EOP.
    - A beat accepted during ISSUE is processed normally: tlast on it → IDLE.
  - WAIT_EOP: discard beats until accepted tlast → IDLE.
- `reset` in any state → IDLE. The next accepted beat is treated as a start of packet, and no request is issued for the interrupted packet.

## Timing
- Reset values: `tuple` = 0, `src_port` = 0, `lookup_req` = 0, state IDLE.
- `lookup_req` rises exactly 1 cycle after the deciding beat is accepted. Its outputs are registered.
- Decision beat by packet type:
  - IPv4 IHL 5–9 TCP/UDP, or non-TCP/UDP/fragment: beat 1 (dst_ip finishes at byte 33).
  - IHL 10–15 TCP/UDP: beat 1 when L+3 ≤ 63, else beat 2.
  - Non-IPv4: beat 0.
- Back-to-back packets are allowed: a one-beat packet every cycle produces `lookup_req` every cycle, each cycle carrying that packet's tuple.
- There is no backpressure on `lookup_req`. The consumer must accept one request per cycle; the downstream filter's fixed 3-cycle pipeline does.

## Test plan
- TCP, IHL 5, 10.0.0.1→10.0.0.2, ports 0x1234→0x0050, tuser src 0x04, 2 beats → `tuple` = 0x0A000001_0A000002_06_1234_0050, `src_port` = 0x04, one `lookup_req` 1 cycle after beat 1.
- UDP, IHL 15, 3-beat packet with tvalid gaps and tready stalls inserted → single `lookup_req` 1 cycle after accepted beat 2, correct ports from bytes 74–77.
- ARP (ethertype 0x0806), 2 beats → `tuple` = 0, `lookup_req` 1 cycle after beat 0, no second pulse.
- IPv4 proto 1 (ICMP), and separately a TCP packet with fragment offset 0x10 → ports = 0, IP/proto fields correct.
- IPv4 TCP packet of 30 bytes (single beat with tlast), followed immediately by a valid TCP packet → first `tuple` = 0, second tuple correct, two pulses.
- Reset asserted during beat 1 of a TCP packet, then a fresh packet → no request for the aborted packet; the fresh packet yields one correct `lookup_req`; all outputs read 0 in the cycle after reset.

Source files
------------

// File: rtl/osnt_tuple_extractor.sv
// Passive IPv4 5-tuple extractor tapping an AXI4-Stream; issues one lookup
// request per packet to the downstream packet filter without touching the stream.
module osnt_tuple_extractor #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int TUPLE_WIDTH          = 104,
  parameter int NUM_QUEUES           = 8,
  parameter int SRC_PORT_POS         = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [TUPLE_WIDTH-1:0]          tuple,
  output logic [NUM_QUEUES-1:0]           src_port,
  output logic                            lookup_req,
  output logic [1:0]                      fsm_state
);

  // Stream handshake: a beat exists only when tvalid and tready are both high
  // on a rising clk edge; this block never drives either signal.
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_ISSUE, S_WAIT} state_t;
  state_t state;

  function automatic logic [7:0] byte_at(input logic [C_S_AXIS_DATA_WIDTH-1:0] d,
                                         input logic [4:0] k);
    return d[{k, 3'b000} +: 8];
  endfunction

  logic                  acc, take_sop;
  logic [15:0]           b0_eth;
  logic [7:0]            b0_vihl, b0_proto;
  logic [12:0]           b0_frag;
  logic                  b0_ipv4, b0_l4;
  logic [6:0]            b0_l4pos, b0_last_byte;
  logic [6:0]            pos;
  logic [31:0]           cur_dst, cur_ports;
  logic [TUPLE_WIDTH-1:0] hdr_tuple;

  logic [31:0]           src_ip_r, dst_ip_r, port_r;
  logic [7:0]            proto_r;
  logic                  l4_r, issue_last;
  logic [6:0]            l4pos_r;
  logic [1:0]            dec_beat_r, beat_cnt;
  logic [NUM_QUEUES-1:0] src_port_r;

  assign acc       = s_axis_tvalid & s_axis_tready;
  // After a request whose packet already ended, the next beat starts a packet.
  assign take_sop  = acc & ((state == S_IDLE) | ((state == S_ISSUE) & issue_last));
  assign fsm_state = state;

  always_comb begin
    b0_eth       = {byte_at(s_axis_tdata, 5'd12), byte_at(s_axis_tdata, 5'd13)};
    b0_vihl      = byte_at(s_axis_tdata, 5'd14);
    b0_frag      = {byte_at(s_axis_tdata, 5'd20), byte_at(s_axis_tdata, 5'd21)} & 16'h1fff;
    b0_proto     = byte_at(s_axis_tdata, 5'd23);
    b0_ipv4      = (b0_eth == 16'h0800) && (b0_vihl[7:4] == 4'd4) && (b0_vihl[3:0] >= 4'd5);
    b0_l4        = ((b0_proto == 8'd6) || (b0_proto == 8'd17)) && (b0_frag == 13'd0);
    b0_l4pos     = 7'd14 + {1'b0, b0_vihl[3:0], 2'b00};
    b0_last_byte = b0_l4 ? (b0_l4pos + 7'd3) : 7'd33;
  end

  // Merge the bytes of the current header beat over what earlier beats captured.
  always_comb begin
    pos       = '0;
    cur_ports = port_r;
    cur_dst   = dst_ip_r;
    if (beat_cnt == 2'd1)
      cur_dst = {dst_ip_r[31:16], byte_at(s_axis_tdata, 5'd0), byte_at(s_axis_tdata, 5'd1)};
    for (int i = 0; i < 4; i++) begin
      pos = l4pos_r + 7'(i);
      if (pos[6:5] == beat_cnt)
        cur_ports[8*(3-i) +: 8] = byte_at(s_axis_tdata, pos[4:0]);
    end
    hdr_tuple = {src_ip_r, cur_dst, proto_r, (l4_r ? cur_ports : 32'd0)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      tuple      <= '0;
      src_port   <= '0;
      lookup_req <= 1'b0;
      issue_last <= 1'b0;
      beat_cnt   <= '0;
      src_ip_r   <= '0;
      dst_ip_r   <= '0;
      port_r     <= '0;
      proto_r    <= '0;
      l4_r       <= 1'b0;
      l4pos_r    <= '0;
      dec_beat_r <= '0;
      src_port_r <= '0;
    end else begin
      lookup_req <= 1'b0;
      if (take_sop) begin
        src_port_r <= s_axis_tuser[SRC_PORT_POS +: NUM_QUEUES];
        src_ip_r   <= {byte_at(s_axis_tdata, 5'd26), byte_at(s_axis_tdata, 5'd27),
                       byte_at(s_axis_tdata, 5'd28), byte_at(s_axis_tdata, 5'd29)};
        dst_ip_r   <= {byte_at(s_axis_tdata, 5'd30), byte_at(s_axis_tdata, 5'd31), 16'h0000};
        proto_r    <= b0_proto;
        l4_r       <= b0_l4;
        l4pos_r    <= b0_l4pos;
        dec_beat_r <= b0_last_byte[6:5];
        port_r     <= '0;
        beat_cnt   <= 2'd1;
        if (!b0_ipv4 || s_axis_tlast) begin
          lookup_req <= 1'b1;
          tuple      <= '0;
          src_port   <= s_axis_tuser[SRC_PORT_POS +: NUM_QUEUES];
          issue_last <= s_axis_tlast;
          state      <= S_ISSUE;
        end else begin
          state <= S_HDR;
        end
      end else begin
        case (state)
          S_HDR: if (acc) begin
            if (beat_cnt == dec_beat_r) begin
              lookup_req <= 1'b1;
              tuple      <= hdr_tuple;
              src_port   <= src_port_r;
              issue_last <= s_axis_tlast;
              state      <= S_ISSUE;
            end else if (s_axis_tlast) begin
              lookup_req <= 1'b1;
              tuple      <= '0;
              src_port   <= src_port_r;
              issue_last <= 1'b1;
              state      <= S_ISSUE;
            end else begin
              beat_cnt <= beat_cnt + 2'd1;
              dst_ip_r <= cur_dst;
              port_r   <= cur_ports;
            end
          end
          S_ISSUE: state <= (issue_last || (acc && s_axis_tlast)) ? S_IDLE : S_WAIT;
          S_WAIT:  if (acc && s_axis_tlast) state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_osnt_tuple_extractor.sv
// Bench for osnt_tuple_extractor: builds packets as byte lists, predicts each
// lookup from the header-field rules, and scores every request pulse.
module tb_osnt_tuple_extractor;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [255:0] s_axis_tdata = '0;
  logic [127:0] s_axis_tuser = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready = 1'b0;
  logic         s_axis_tlast = 1'b0;
  logic [103:0] tuple;
  logic [7:0]   src_port;
  logic         lookup_req;
  logic [1:0]   fsm_state;

  osnt_tuple_extractor dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast),
    .tuple(tuple), .src_port(src_port), .lookup_req(lookup_req),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  // Entry: {pulse cycle[31:0], src_port[7:0], tuple[103:0]}
  logic [143:0] exp_q[$];
  logic [7:0]   pkt[$];
  logic [143:0] mon_e;

  task automatic chk(input string tag, input logic [103:0] obs, input logic [103:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (lookup_req === 1'b1) begin
      chk("req_expected", 104'(exp_q.size() > 0), 104'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("tuple", tuple, mon_e[103:0]);
        chk("src_port", 104'(src_port), 104'(mon_e[111:104]));
        chk("req_cycle", 104'(cyc), 104'(mon_e[143:112]));
      end
    end
  end

  task automatic put(input int idx, input logic [7:0] v);
    if (idx < pkt.size()) pkt[idx] = v;
  endtask

  task automatic build(input logic [15:0] eth, input logic [7:0] vihl, input logic [15:0] frag,
                       input logic [7:0] proto, input logic [31:0] sip, input logic [31:0] dip,
                       input logic [15:0] sp, input logic [15:0] dp, input int len);
    int nb, l4;
    nb = (len + 31) / 32;
    l4 = 14 + 4 * int'(vihl[3:0]);
    pkt.delete();
    for (int i = 0; i < nb * 32; i++) pkt.push_back(8'($urandom));
    put(12, eth[15:8]); put(13, eth[7:0]); put(14, vihl);
    put(20, frag[15:8]); put(21, frag[7:0]); put(23, proto);
    for (int k = 0; k < 4; k++) begin
      put(26 + k, sip[8*(3-k) +: 8]);
      put(30 + k, dip[8*(3-k) +: 8]);
    end
    if (vihl[3:0] >= 4'd5) begin
      put(l4, sp[15:8]); put(l4 + 1, sp[7:0]); put(l4 + 2, dp[15:8]); put(l4 + 3, dp[7:0]);
    end
  endtask

  // Reference: expected tuple and index of the beat after which the request follows.
  task automatic model(output logic [103:0] t, output int dbeat);
    int nb, ihl, l4, last;
    logic [15:0] eth, frag;
    logic [7:0] proto;
    logic ipv4, ports;
    nb    = pkt.size() / 32;
    eth   = {pkt[12], pkt[13]};
    ihl   = int'(pkt[14][3:0]);
    frag  = {pkt[20], pkt[21]} & 16'h1fff;
    proto = pkt[23];
    ipv4  = (eth == 16'h0800) && (pkt[14][7:4] == 4'd4) && (ihl >= 5);
    ports = (proto == 8'd6 || proto == 8'd17) && (frag == 16'd0);
    l4    = 14 + 4 * ihl;
    last  = ports ? l4 + 3 : 33;
    if (!ipv4) begin
      t = '0; dbeat = 0;
    end else if (nb < last / 32 + 1) begin
      t = '0; dbeat = nb - 1;
    end else begin
      dbeat = last / 32;
      t = {pkt[26], pkt[27], pkt[28], pkt[29], pkt[30], pkt[31], pkt[32], pkt[33], proto,
           (ports ? {pkt[l4], pkt[l4+1], pkt[l4+2], pkt[l4+3]} : 32'd0)};
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic send(input logic [7:0] port, input bit gaps, input int abort_beat);
    logic [103:0] et;
    logic [255:0] d;
    int db, nb;
    bit acc;
    model(et, db);
    nb = pkt.size() / 32;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < 32; k++) d[8*k +: 8] = pkt[32*b + k];
      acc = 1'b0;
      while (!acc) begin
        s_axis_tvalid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        s_axis_tready = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (b == abort_beat) begin
          reset = 1'b1; s_axis_tvalid = 1'b1; s_axis_tready = 1'b1;
        end
        s_axis_tuser = {$urandom, $urandom, $urandom, $urandom};
        if (s_axis_tvalid) begin
          s_axis_tdata = d;
          s_axis_tlast = (b == nb - 1);
          s_axis_tuser[16 +: 8] = port;
        end else begin
          s_axis_tdata = rand256();
          s_axis_tlast = 1'($urandom);
        end
        @(posedge clk);
        acc = s_axis_tvalid && s_axis_tready;
        if (acc && b == abort_beat) begin
          #1;
          chk("post_reset_tuple", tuple, 104'd0);
          chk("post_reset_src_port", 104'(src_port), 104'd0);
          chk("post_reset_req", 104'(lookup_req), 104'd0);
          chk("post_reset_state", 104'(fsm_state), 104'd0);
          reset = 1'b0;
          s_axis_tvalid = 1'b0;
          return;
        end
        if (acc && b == db) exp_q.push_back({32'(cyc + 1), port, et});
        #1;
      end
    end
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] eth, frag;
    logic [7:0] vihl, proto, port;
    int kind;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tuple", tuple, 104'd0);
    chk("reset_src_port", 104'(src_port), 104'd0);
    chk("reset_req", 104'(lookup_req), 104'd0);
    chk("reset_state", 104'(fsm_state), 104'd0);
    reset = 1'b0;
    idle(2);

    // TCP IHL 5, 10.0.0.1 -> 10.0.0.2, 0x1234 -> 0x0050
    build(16'h0800, 8'h45, 16'h0000, 8'd6, 32'h0A000001, 32'h0A000002, 16'h1234, 16'h0050, 60);
    send(8'h04, 1'b0, -1);
    idle(3);
    chk("tcp_ihl5_literal", tuple, 104'h0A000001_0A000002_06_1234_0050);
    chk("tcp_ihl5_port", 104'(src_port), 104'h04);

    // UDP IHL 15, 3 beats, gaps and stalls
    build(16'h0800, 8'h4F, 16'h0000, 8'd17, 32'hC0A80101, 32'hC0A80202, 16'hABCD, 16'h0035, 90);
    send(8'h10, 1'b1, -1);
    idle(3);
    chk("udp_ihl15_ports", 104'(tuple[31:0]), 104'hABCD0035);

    // ARP, ICMP, fragmented TCP
    build(16'h0806, 8'h45, 16'h0000, 8'd6, 32'h01020304, 32'h05060708, 16'h1111, 16'h2222, 60);
    send(8'h01, 1'b0, -1);
    idle(2);
    build(16'h0800, 8'h45, 16'h0000, 8'd1, 32'h0B0B0B0B, 32'h0C0C0C0C, 16'h3333, 16'h4444, 64);
    send(8'h02, 1'b0, -1);
    idle(2);
    build(16'h0800, 8'h45, 16'h0010, 8'd6, 32'h0D0D0D0D, 32'h0E0E0E0E, 16'h5555, 16'h6666, 64);
    send(8'h08, 1'b0, -1);
    idle(3);
    chk("frag_ports_zero", 104'(tuple[31:0]), 104'd0);

    // 30-byte TCP then a full TCP, back to back
    build(16'h0800, 8'h45, 16'h0000, 8'd6, 32'h0A0A0A0A, 32'h0B0B0B0B, 16'h7777, 16'h8888, 30);
    send(8'h20, 1'b0, -1);
    build(16'h0800, 8'h46, 16'h0000, 8'd6, 32'h0A0A0A0B, 32'h0B0B0B0C, 16'h9999, 16'hAAAA, 64);
    send(8'h40, 1'b0, -1);
    idle(2);

    // One-beat packets every cycle
    for (int i = 0; i < 5; i++) begin
      build(16'(i[0] ? 16'h0800 : 16'h86DD), 8'h45, 16'h0000, 8'd6, $urandom, $urandom,
            16'($urandom), 16'($urandom), 20);
      send(8'(1 << i), 1'b0, -1);
    end
    idle(2);

    // Reset during beat 1 of a TCP packet, then a fresh packet
    build(16'h0800, 8'h45, 16'h0000, 8'd6, 32'h11111111, 32'h22222222, 16'h0001, 16'h0002, 64);
    send(8'h80, 1'b0, 1);
    build(16'h0800, 8'h45, 16'h0000, 8'd17, 32'h33333333, 32'h44444444, 16'h0003, 16'h0004, 64);
    send(8'h80, 1'b0, -1);
    idle(2);

    // Randomised packets
    for (int n = 0; n < 60; n++) begin
      kind  = $urandom_range(0, 9);
      eth   = (kind == 0) ? 16'h0806 : 16'h0800;
      vihl  = {((kind == 1) ? 4'h6 : 4'h4),
               ((kind == 2) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(5, 15)))};
      case ($urandom_range(0, 3))
        0: proto = 8'd6;
        1: proto = 8'd17;
        2: proto = 8'd1;
        default: proto = 8'($urandom);
      endcase
      frag  = (kind == 3) ? 16'($urandom) : (($urandom_range(0, 3) == 0) ? 16'h4000 : 16'h0000);
      port  = 8'(1 << $urandom_range(0, 7));
      build(eth, vihl, frag, proto, $urandom, $urandom, 16'($urandom), 16'($urandom),
            $urandom_range(14, 100));
      send(port, 1'($urandom), -1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    idle(5);
    chk("pending_requests", 104'(exp_q.size()), 104'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
